// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 4-bit LCD controller: self-timed power-up init, host byte interface
// over valid/ready, cursor tracking with optional automatic line wrap.
module lcd_hd44780_ctrl #(
  parameter int CLK_HZ    = 1000000,
  parameter int ROWS      = 2,
  parameter int COLS      = 16,
  parameter int EN_CYCLES = 1,
  parameter int AUTOWRAP  = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       init_done,
  output logic [1:0] cursor_row,
  output logic [5:0] cursor_col,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic [3:0] lcd_data
);
  function automatic logic [31:0] cyc(input longint us);
    longint c;
    c = (longint'(CLK_HZ) * us + longint'(999999)) / longint'(1000000);
    return (c < 1) ? 32'd1 : 32'(c);
  endfunction

  localparam logic [31:0] T_PWR   = cyc(40000);
  localparam logic [31:0] T_5MS   = cyc(5000);
  localparam logic [31:0] T_200   = cyc(200);
  localparam logic [31:0] T_S     = cyc(50);
  localparam logic [31:0] T_L     = cyc(2000);
  localparam logic [31:0] EN_CNT  = 32'(EN_CYCLES);
  localparam logic [31:0] NIB_END = 32'(EN_CYCLES + 1);
  localparam logic [5:0]  COL_MAX = 6'(COLS);
  localparam logic [5:0]  COL_LST = 6'(COLS - 1);
  localparam logic [1:0]  ROW_LST = 2'(ROWS - 1);
  localparam logic [7:0]  COLS8   = 8'(COLS);
  localparam logic [7:0]  FUNCSET = (ROWS > 1) ? 8'h28 : 8'h20;

  function automatic logic [6:0] row_base(input logic [1:0] r);
    case (r)
      2'd0:    return 7'h00;
      2'd1:    return 7'h40;
      2'd2:    return 7'h14;
      default: return 7'h54;
    endcase
  endfunction

  // Steps 0..3 are single nibbles (value in the low half), 4..7 are full bytes.
  function automatic logic [7:0] init_byte(input logic [2:0] s);
    case (s)
      3'd0, 3'd1, 3'd2: return 8'h03;
      3'd3:             return 8'h02;
      3'd4:             return FUNCSET;
      3'd5:             return 8'h0C;
      3'd6:             return 8'h06;
      default:          return 8'h01;
    endcase
  endfunction

  function automatic logic [31:0] init_wait(input logic [2:0] s);
    case (s)
      3'd0:       return T_5MS;
      3'd1, 3'd2: return T_200;
      3'd7:       return T_L;
      default:    return T_S;
    endcase
  endfunction

  typedef enum logic [2:0] {S_PWRUP, S_IDLE, S_LOAD, S_HI, S_LO, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d, wait_q, wait_d;
  logic [2:0]  step_q, step_d, nstep;
  logic [7:0]  byte_q, byte_d, ib, addr, off, base_a;
  logic [31:0] iw;
  logic        brs_q, brs_d, wrap_q, wrap_d, done_q, done_d, nrs_q, nrs_d, launch;
  logic [1:0]  row_q, row_d;
  logic [5:0]  col_q, col_d;
  logic [3:0]  nib_q, nib_d;

  // Handshake: wr_ready is high only in IDLE; a byte transfers on the clock edge
  // where wr_valid && wr_ready, and the host holds wr_valid/wr_rs/wr_data until then.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    step_d  = step_q;
    byte_d  = byte_q;
    brs_d   = brs_q;
    wrap_d  = wrap_q;
    done_d  = done_q;
    row_d   = row_q;
    col_d   = col_q;
    nib_d   = nib_q;
    nrs_d   = nrs_q;
    launch  = 1'b0;
    nstep   = (state_q == S_PWRUP) ? 3'd0 : step_q + 3'd1;
    ib      = init_byte(nstep);
    iw      = init_wait(nstep);
    addr    = {1'b0, wr_data[6:0]};
    off     = 8'd0;
    base_a  = 8'd0;
    wr_ready = (state_q == S_IDLE);
    lcd_en   = ((state_q == S_HI) || (state_q == S_LO)) && (cnt_q != 32'd0) && (cnt_q <= EN_CNT);
    case (state_q)
      S_PWRUP: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == T_PWR - 32'd1) launch = 1'b1;
      end
      S_IDLE: if (wr_valid) begin
        byte_d  = wr_data;
        brs_d   = wr_rs;
        wait_d  = (!wr_rs && (wr_data == 8'h01 || wr_data == 8'h02 || wr_data == 8'h03)) ? T_L : T_S;
        state_d = S_LOAD;
        if (wr_rs) begin
          if (col_q < COL_MAX) col_d = col_q + 6'd1;
          if (AUTOWRAP != 0 && col_q == COL_LST) wrap_d = 1'b1;
        end else if (wr_data == 8'h01 || wr_data == 8'h02 || wr_data == 8'h03) begin
          row_d = 2'd0;
          col_d = 6'd0;
        end else if (wr_data[7]) begin
          // Descending scan so the lowest matching row wins on overlapping ranges.
          for (int r = ROWS - 1; r >= 0; r--) begin
            base_a = {1'b0, row_base(2'(r))};
            off    = addr - base_a;
            if (addr >= base_a && off < COLS8) begin
              row_d = 2'(r);
              col_d = off[5:0];
            end
          end
        end
      end
      S_LOAD: begin
        state_d = S_HI;
        cnt_d   = 32'd0;
        nib_d   = byte_q[7:4];
        nrs_d   = brs_q;
      end
      S_HI: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == NIB_END) begin
          state_d = S_LO;
          cnt_d   = 32'd0;
          nib_d   = byte_q[3:0];
        end
      end
      S_LO: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == NIB_END) begin
          state_d = S_WAIT;
          cnt_d   = 32'd0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == wait_q - 32'd1) begin
          cnt_d = 32'd0;
          if (!done_q) begin
            if (step_q == 3'd7) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              launch = 1'b1;
            end
          end else if (wrap_q) begin
            wrap_d  = 1'b0;
            row_d   = (row_q == ROW_LST) ? 2'd0 : row_q + 2'd1;
            col_d   = 6'd0;
            byte_d  = {1'b1, row_base(row_d)};
            brs_d   = 1'b0;
            wait_d  = T_S;
            state_d = S_HI;
            nib_d   = byte_d[7:4];
            nrs_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_PWRUP;
    endcase
    if (launch) begin
      step_d = nstep;
      byte_d = ib;
      brs_d  = 1'b0;
      wait_d = iw;
      cnt_d  = 32'd0;
      nrs_d  = 1'b0;
      if (nstep < 3'd4) begin
        state_d = S_LO;
        nib_d   = ib[3:0];
      end else begin
        state_d = S_HI;
        nib_d   = ib[7:4];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_PWRUP;
      cnt_q   <= 32'd0;
      wait_q  <= 32'd0;
      step_q  <= 3'd0;
      byte_q  <= 8'd0;
      brs_q   <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      row_q   <= 2'd0;
      col_q   <= 6'd0;
      nib_q   <= 4'd0;
      nrs_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      step_q  <= step_d;
      byte_q  <= byte_d;
      brs_q   <= brs_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
      row_q   <= row_d;
      col_q   <= col_d;
      nib_q   <= nib_d;
      nrs_q   <= nrs_d;
    end
  end

  assign init_done  = done_q;
  assign cursor_row = row_q;
  assign cursor_col = col_q;
  assign lcd_rs     = nrs_q;
  assign lcd_data   = nib_q;
endmodule
